exu_bru: RTL and testbench
==========================

EXU_BRU -- requirements
Module: exu_bru

Interface
REQ-001 Parameter AW, default 32: address/PC width.
REQ-002 Parameter DW, default 32: operand width, DW >= 32.
REQ-003 Parameter DEPTH, default 4: response queue depth, power of two, >= 2.
REQ-004 clk  input  1  clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  discard all queued responses.
REQ-007 req_vld  input  1  request valid.
REQ-008 req_rdy  output  1  request ready.
REQ-009 req_ir  input  32  instruction word.
REQ-010 req_pc  input  AW  instruction PC.
REQ-011 req_rs1  input  DW  rs1 value.
REQ-012 req_rs2  input  DW  rs2 value.
REQ-013 rsp_vld  output  1  response valid.
REQ-014 rsp_rdy  input  1  response consumer ready.
REQ-015 rsp_taken  output  1  redirect required.
REQ-016 rsp_offset  output  AW  sign-extended immediate, else 4.
REQ-017 rsp_target  output  AW  redirect target, else pc+4.
REQ-018 rsp_illegal  output  1  undefined branch funct3.
REQ-019 taken_cnt  output  32  count of taken responses popped.

Function
REQ-020 Request accepted iff req_vld & req_rdy on a rising clk edge; response accepted iff rsp_vld & rsp_rdy.
REQ-021 req_rdy = (occupancy < DEPTH) & ~flush, combinational from registered occupancy only, never from req_vld.
REQ-022 Accepted request resolved combinationally and written into the queue at the accept edge; rsp_vld asserts the next cycle (latency 1); order preserved.
REQ-023 Opcode 1100011 (branch): funct3 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU; compare on low 32 bits of rs1/rs2 and on the signedness given; offset = B-immediate; target = pc+offset if taken, else pc+4.
REQ-024 Branch funct3 010/011: rsp_illegal=1, taken=0, offset=4, target=pc+4.
REQ-025 Opcode 1101111 (JAL): taken=1, offset = J-immediate, target = pc+offset.
REQ-026 Opcode 1100111 (JALR): taken=1, offset = I-immediate, target = (rs1+offset) with bit 0 cleared.
REQ-027 Any other opcode: taken=0, illegal=0, offset=4, target=pc+4.
REQ-028 Address arithmetic modulo 2^AW; immediates sign-extended to AW.
REQ-029 Outputs rsp_* hold stable while rsp_vld & ~rsp_rdy.
REQ-030 Full queue: req_rdy=0; simultaneous pop frees a slot only in the following cycle.
REQ-031 Empty queue: rsp_vld=0; rsp_* payload don't-care.
REQ-032 Flush: occupancy, read and write pointers to 0 at that edge; no push and no pop that cycle; taken_cnt unchanged.
REQ-033 taken_cnt increments by 1 on each popped response with rsp_taken=1; saturates at 0xFFFFFFFF.

Reset
REQ-034 During and after reset: req_rdy=0 while rst_n low, rsp_vld=0, occupancy=0, pointers=0, taken_cnt=0.
REQ-035 Reset asserted mid-operation discards all queued responses immediately; req_rdy=1 on the first cycle after rst_n deasserts.

Structure
REQ-036 Package exu_pkg holds opcode constants, branch funct3 enum and the response packet struct (taken, illegal, offset, target).
REQ-037 Queue is one sub-module, sync_fifo, parametrised by width and DEPTH, with flush input; resolve logic stays in exu_bru.

Verification
REQ-038 Reset, then idle -> req_rdy=1, rsp_vld=0, taken_cnt=0.
REQ-039 BEQ ir=0x00000863, pc=0x100, rs1=rs2=5 -> next cycle rsp_taken=1, offset=0x10, target=0x110; rs2=6 -> taken=0, target=0x104.
REQ-040 JAL ir=0xFF9FF06F, pc=0x200 -> taken=1, offset=0xFFFFFFF8, target=0x1F8, taken_cnt=1 after pop.
REQ-041 rsp_rdy=0, push DEPTH+1 requests -> req_rdy drops after 4th accept; release rsp_rdy -> 4 responses in order, payload stable while stalled.
REQ-042 3 queued, flush=1 with req_vld=1 -> next cycle rsp_vld=0, request not accepted, taken_cnt unchanged.
REQ-043 BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1; BLTU same operands -> taken=0; funct3=010 -> illegal=1.

Source files
------------

// File: rtl/exu_pkg.sv
// Shared definitions for the branch resolution unit: opcodes, branch funct3
// encodings and the response packet carried through the response queue.
package exu_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Address fields in the packet are PKT_AW wide; exu_bru narrows them to AW.
  localparam int PKT_AW = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef struct packed {
    logic              taken;
    logic              illegal;
    logic [PKT_AW-1:0] offset;
    logic [PKT_AW-1:0] target;
  } bru_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through read of the head entry and a flush that
// empties the queue in one edge, overriding any push or pop in that cycle.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries below count_q are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/exu_bru.sv
// Branch resolution unit: decodes branch/JAL/JALR, resolves direction and
// target in the accept cycle, and queues the result for an in-order consumer.
module exu_bru
  import exu_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic [31:0]   req_ir,
  input  logic [AW-1:0] req_pc,
  input  logic [DW-1:0] req_rs1,
  input  logic [DW-1:0] req_rs2,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic          rsp_taken,
  output logic [AW-1:0] rsp_offset,
  output logic [AW-1:0] rsp_target,
  output logic          rsp_illegal,
  output logic [31:0]   taken_cnt
);

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [AW-1:0] b_imm, j_imm, i_imm, pc_plus4, rs1_a;
  logic [31:0]   rs1_lo, rs2_lo;
  logic          cond;
  logic          res_taken, res_illegal;
  logic [AW-1:0] res_offset, res_target;
  bru_rsp_t      wr_pkt, rd_pkt;
  logic          push, pop, fifo_empty, fifo_full;
  logic [31:0]   taken_cnt_q, taken_cnt_d;

  assign opcode   = req_ir[6:0];
  assign funct3   = req_ir[14:12];
  assign b_imm    = AW'($signed({req_ir[31], req_ir[7], req_ir[30:25], req_ir[11:8], 1'b0}));
  assign j_imm    = AW'($signed({req_ir[31], req_ir[19:12], req_ir[20], req_ir[30:21], 1'b0}));
  assign i_imm    = AW'($signed(req_ir[31:20]));
  assign pc_plus4 = req_pc + AW'(4);
  assign rs1_a    = AW'(req_rs1);
  assign rs1_lo   = req_rs1[31:0];
  assign rs2_lo   = req_rs2[31:0];

  always_comb begin
    cond        = 1'b0;
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    res_offset  = AW'(4);
    res_target  = pc_plus4;
    case (opcode)
      OPC_BRANCH: begin
        res_illegal = 1'b0;
        case (funct3)
          F3_BEQ:  cond = (rs1_lo == rs2_lo);
          F3_BNE:  cond = (rs1_lo != rs2_lo);
          F3_BLT:  cond = ($signed(rs1_lo) <  $signed(rs2_lo));
          F3_BGE:  cond = ($signed(rs1_lo) >= $signed(rs2_lo));
          F3_BLTU: cond = (rs1_lo <  rs2_lo);
          F3_BGEU: cond = (rs1_lo >= rs2_lo);
          default: res_illegal = 1'b1;
        endcase
        // Defined branches report their immediate even when not taken.
        if (!res_illegal) begin
          res_taken  = cond;
          res_offset = b_imm;
          res_target = cond ? (req_pc + b_imm) : pc_plus4;
        end
      end
      OPC_JAL: begin
        res_taken  = 1'b1;
        res_offset = j_imm;
        res_target = req_pc + j_imm;
      end
      OPC_JALR: begin
        res_taken  = 1'b1;
        res_offset = i_imm;
        res_target = (rs1_a + i_imm) & ~AW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_pkt.taken   = res_taken;
    wr_pkt.illegal = res_illegal;
    wr_pkt.offset  = PKT_AW'(res_offset);
    wr_pkt.target  = PKT_AW'(res_target);
  end

  assign req_rdy = rst_n & ~flush & ~fifo_full;
  assign push    = req_vld & req_rdy;
  assign rsp_vld = ~fifo_empty;
  assign pop     = rsp_vld & rsp_rdy & ~flush;

  sync_fifo #(
    .W     ($bits(bru_rsp_t)),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (wr_pkt),
    .pop   (pop),
    .rdata (rd_pkt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rsp_taken   = rd_pkt.taken;
  assign rsp_illegal = rd_pkt.illegal;
  assign rsp_offset  = AW'(rd_pkt.offset);
  assign rsp_target  = AW'(rd_pkt.target);

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (pop && rd_pkt.taken && (taken_cnt_q != 32'hFFFF_FFFF))
      taken_cnt_d = taken_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) taken_cnt_q <= '0;
    else        taken_cnt_q <= taken_cnt_d;
  end

  assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_exu_bru.sv
// Self-checking bench for exu_bru: hand-computed vector table pushed to a
// scoreboard on accept and compared on each popped response, plus corner cases.
module tb_exu_bru;

  logic        clk = 1'b0;
  logic        rst_n, flush, req_vld, rsp_rdy;
  logic        req_rdy, rsp_vld, rsp_taken, rsp_illegal;
  logic [31:0] req_ir, req_pc, req_rs1, req_rs2;
  logic [31:0] rsp_offset, rsp_target, taken_cnt;

  always #5 clk = ~clk;

  exu_bru dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_ir      (req_ir),
    .req_pc      (req_pc),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .rsp_vld     (rsp_vld),
    .rsp_rdy     (rsp_rdy),
    .rsp_taken   (rsp_taken),
    .rsp_offset  (rsp_offset),
    .rsp_target  (rsp_target),
    .rsp_illegal (rsp_illegal),
    .taken_cnt   (taken_cnt)
  );

  typedef struct packed {
    logic        taken;
    logic        illegal;
    logic [31:0] offset;
    logic [31:0] target;
  } exp_t;

  typedef struct {
    logic [31:0] ir, pc, rs1, rs2;
    exp_t        exp;
  } vec_t;

  vec_t        vecs [15];
  exp_t        sb [$];
  exp_t        cur_exp;
  exp_t        hold_val;
  logic        hold_vld = 1'b0;
  logic        last_acc = 1'b0;
  int          total = 0;
  int          bad = 0;
  int unsigned exp_cnt = 0;

  function automatic vec_t mk(logic [31:0] ir, logic [31:0] pc, logic [31:0] rs1,
                              logic [31:0] rs2, logic t, logic il,
                              logic [31:0] off, logic [31:0] tgt);
    vec_t v;
    v.ir = ir; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.exp = '{taken: t, illegal: il, offset: off, target: tgt};
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(int i);
    req_ir  = vecs[i].ir;
    req_pc  = vecs[i].pc;
    req_rs1 = vecs[i].rs1;
    req_rs2 = vecs[i].rs2;
    cur_exp = vecs[i].exp;
    req_vld = 1'b1;
  endtask

  // Called at a negedge with inputs set: scores the coming clock edge.
  task automatic cycle();
    exp_t e;
    exp_t now;
    #1;
    now = '{taken: rsp_taken, illegal: rsp_illegal, offset: rsp_offset, target: rsp_target};
    if (hold_vld) begin
      chk("stall_vld", rsp_vld, 1'b1);
      chk("stall_payload", now, hold_val);
    end
    if (rsp_vld && rsp_rdy && !flush) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1'b1, 1'b0);
      else begin
        e = sb.pop_front();
        chk("rsp_taken", rsp_taken, e.taken);
        chk("rsp_illegal", rsp_illegal, e.illegal);
        chk("rsp_offset", rsp_offset, e.offset);
        chk("rsp_target", rsp_target, e.target);
        if (e.taken && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      end
    end
    if (flush) sb.delete();
    last_acc = req_vld && req_rdy;
    if (last_acc) sb.push_back(cur_exp);
    hold_vld = rsp_vld && !rsp_rdy && !flush;
    hold_val = now;
    @(negedge clk);
  endtask

  initial begin
    int idx;
    int unsigned saved_cnt;
    vecs[0]  = mk(32'h00000863, 32'h100, 32'd5, 32'd5, 1, 0, 32'h10, 32'h110);
    vecs[1]  = mk(32'h00000863, 32'h100, 32'd5, 32'd6, 0, 0, 32'h10, 32'h104);
    vecs[2]  = mk(32'hFF9FF06F, 32'h200, 32'd0, 32'd0, 1, 0, 32'hFFFFFFF8, 32'h1F8);
    vecs[3]  = mk(32'h00004863, 32'h100, 32'hFFFFFFFF, 32'd1, 1, 0, 32'h10, 32'h110);
    vecs[4]  = mk(32'h00006863, 32'h100, 32'hFFFFFFFF, 32'd1, 0, 0, 32'h10, 32'h104);
    vecs[5]  = mk(32'h00002863, 32'h100, 32'd1, 32'd1, 0, 1, 32'h4, 32'h104);
    vecs[6]  = mk(32'h00001863, 32'h300, 32'd5, 32'd6, 1, 0, 32'h10, 32'h310);
    vecs[7]  = mk(32'h00005863, 32'h400, 32'd1, 32'hFFFFFFFF, 1, 0, 32'h10, 32'h410);
    vecs[8]  = mk(32'h00007863, 32'h400, 32'd1, 32'hFFFFFFFF, 0, 0, 32'h10, 32'h404);
    vecs[9]  = mk(32'hFE000CE3, 32'h4, 32'd7, 32'd7, 1, 0, 32'hFFFFFFF8, 32'hFFFFFFFC);
    vecs[10] = mk(32'h00C00067, 32'h500, 32'h1001, 32'd0, 1, 0, 32'hC, 32'h100C);
    vecs[11] = mk(32'hFFF00067, 32'h500, 32'h2000, 32'd0, 1, 0, 32'hFFFFFFFF, 32'h1FFE);
    vecs[12] = mk(32'h00500093, 32'h500, 32'd0, 32'd0, 0, 0, 32'h4, 32'h504);
    vecs[13] = mk(32'h00003863, 32'h600, 32'd0, 32'd0, 0, 1, 32'h4, 32'h604);
    vecs[14] = mk(32'h00000013, 32'hFFFFFFFC, 32'd0, 32'd0, 0, 0, 32'h4, 32'h0);

    rst_n = 1'b0; flush = 1'b0; req_vld = 1'b0; rsp_rdy = 1'b1;
    req_ir = '0; req_pc = '0; req_rs1 = '0; req_rs2 = '0; cur_exp = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_rdy", req_rdy, 1'b0);
    chk("rst_rsp_vld", rsp_vld, 1'b0);
    chk("rst_taken_cnt", taken_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_req_rdy", req_rdy, 1'b1);
    chk("idle_rsp_vld", rsp_vld, 1'b0);
    chk("idle_taken_cnt", taken_cnt, 32'd0);
    @(negedge clk);

    // Single JAL: one-cycle latency and counter bump after pop.
    drive(2);
    cycle();
    req_vld = 1'b0;
    chk("latency_vld", rsp_vld, 1'b1);
    repeat (2) cycle();
    chk("jal_taken_cnt", taken_cnt, 32'd1);

    // Table, back to back with the consumer always ready.
    for (int i = 0; i < 15; i++) begin
      drive(i);
      cycle();
      chk("table_accept", last_acc, 1'b1);
    end
    req_vld = 1'b0;
    repeat (3) cycle();
    chk("table_taken_cnt", taken_cnt, exp_cnt);
    chk("table_drained", sb.size(), 0);

    // Fill the queue while stalled; pop on a full queue frees a slot one cycle later.
    rsp_rdy = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      drive(idx);
      cycle();
      if (last_acc) idx++;
    end
    chk("full_accepts", idx, 4);
    chk("full_req_rdy", req_rdy, 1'b0);
    drive(idx);
    rsp_rdy = 1'b1;
    #1;
    chk("full_pop_rdy", req_rdy, 1'b0);
    cycle();
    chk("after_pop_rdy", req_rdy, 1'b1);
    cycle();
    chk("fifth_accept", last_acc, 1'b1);
    req_vld = 1'b0;
    repeat (6) cycle();
    chk("full_drained", sb.size(), 0);
    chk("full_rsp_vld", rsp_vld, 1'b0);

    // Flush with three queued and a request pending.
    rsp_rdy = 1'b0;
    for (int i = 10; i < 13; i++) begin
      drive(i == 12 ? 0 : i);
      cycle();
    end
    req_vld = 1'b0;
    saved_cnt = exp_cnt;
    flush = 1'b1;
    drive(12);
    #1;
    chk("flush_req_rdy", req_rdy, 1'b0);
    cycle();
    flush = 1'b0;
    req_vld = 1'b0;
    #1;
    chk("flush_rsp_vld", rsp_vld, 1'b0);
    chk("flush_taken_cnt", taken_cnt, saved_cnt);
    rsp_rdy = 1'b1;
    repeat (2) cycle();
    chk("flush_still_empty", rsp_vld, 1'b0);

    // Asynchronous reset with responses queued.
    rsp_rdy = 1'b0;
    drive(0); cycle();
    drive(2); cycle();
    req_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_vld", rsp_vld, 1'b0);
    chk("midrst_req_rdy", req_rdy, 1'b0);
    chk("midrst_taken_cnt", taken_cnt, 32'd0);
    sb.delete();
    exp_cnt = 0;
    hold_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_req_rdy", req_rdy, 1'b1);
    chk("postrst_rsp_vld", rsp_vld, 1'b0);
    @(negedge clk);
    rsp_rdy = 1'b1;
    drive(3);
    cycle();
    req_vld = 1'b0;
    repeat (2) cycle();
    chk("postrst_taken_cnt", taken_cnt, 32'd1);
    chk("final_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
